// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch path: FSM encoding and
// the word-alignment mask also used by the program counter.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StErr  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge port.
interface fetch_unit_if;

    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/fetch_unit_byte_swap32.sv
// Pure combinational byte reversal of a 32-bit word; shared with the data-memory side.
module byte_swap32 (
    input  logic [31:0] din,
    output logic [31:0] dout
);

    assign dout = {din[7:0], din[15:8], din[23:16], din[31:24]};

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: turns the phase-f address into an imem request/ack transaction,
// loads the returned word into ir and stalls the phase generator until it arrives.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 64,
    parameter logic [31:0] ERR_WORD   = 32'h0000_0000,
    parameter bit          SWAP_BYTES = 1'b0
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               hlt,
    input  logic               phase_f,
    input  logic [31:0]        pc,
    fetch_unit_if.master       imem,
    output logic [31:0]        ir,
    output logic               ir_valid,
    output logic               stall,
    output logic               fetch_err
);

    localparam bit          TimeoutEn = (TIMEOUT != 0);
    localparam int unsigned CntW      = TimeoutEn ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutEn ? TIMEOUT - 1 : 0);

    fetch_state_e    state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     ir_q, ir_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ir_valid_q, ir_valid_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_swapped;
    logic [31:0]     rdata_in;

    byte_swap32 u_swap (
        .din  (imem.rdata),
        .dout (rdata_swapped)
    );

    assign rdata_in = SWAP_BYTES ? rdata_swapped : imem.rdata;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ir_d       = ir_q;
        cnt_d      = cnt_q;
        ir_valid_d = 1'b0;
        err_d      = err_q;
        unique case (state_q)
            StIdle: begin
                if (phase_f && !hlt) begin
                    addr_d  = pc & WORD_MASK;
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                // Abort wins over both a returning word and an expiring timeout.
                if (hlt) begin
                    state_d = StIdle;
                end else if (imem.ack) begin
                    ir_d       = rdata_in;
                    ir_valid_d = 1'b1;
                    state_d    = StIdle;
                end else if (TimeoutEn && (cnt_q == CntLast)) begin
                    ir_d       = ERR_WORD;
                    ir_valid_d = 1'b1;
                    err_d      = 1'b1;
                    state_d    = StErr;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            ir_q       <= '0;
            cnt_q      <= '0;
            ir_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ir_q       <= ir_d;
            cnt_q      <= cnt_d;
            ir_valid_q <= ir_valid_d;
            err_q      <= err_d;
        end
    end

    assign imem.req  = (state_q == StReq);
    assign imem.addr = addr_q;
    assign ir        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign stall     = (state_q == StReq) || (state_q == StErr);
    assign fetch_err = err_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch side of the program-counter interface: consumes the fetch address that the program counter presents during phase f and turns it into a request/acknowledge transaction on the instruction-memory port. It latches the returned word into the instruction register and holds the phase sequencer via `stall` until the word arrives. A bounded wait with a sticky error guards against a memory that never answers. It sits between the program counter, the phase generator and the instruction memory.

## Interface
Parameters:
- TIMEOUT, 64: maximum cycles spent in REQ waiting for `imem_ack`; 0 disables the timeout.
- ERR_WORD, 32'h0000_0000: value loaded into `ir` on timeout.
- SWAP_BYTES, 0: 1 byte-reverses `imem_rdata` before it is loaded into `ir`.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- n_rst  in  1  reset: synchronous, active-low.
- hlt  in  1  synchronous abort; same priority as reset for the FSM, but `ir` and `fetch_err` are kept.
- phase_f  in  1  fetch-phase strobe from the phase generator.
- pc  in  32  fetch address from the program counter, valid while `phase_f`=1.
- imem_req  out  1  request valid to instruction memory.
- imem_addr  out  32  word address of the request; bits [1:0] are always 0.
- imem_ack  in  1  memory has `imem_rdata` valid this cycle.
- imem_rdata  in  32  instruction word.
- ir  out  32  instruction register.
- ir_valid  out  1  one-cycle pulse: `ir` was updated at the preceding edge.
- stall  out  1  phase generator must not advance past phase r while this is 1.
- fetch_err  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, REQ, ERR.
- IDLE:
  - `phase_f`=1 and `hlt`=0: latch `addr_r` = `pc` & 32'hFFFF_FFFC, clear `wait_cnt`, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `imem_req`=1, `imem_addr`=`addr_r`, both held stable until ack.
  - `imem_ack`=1: `ir` <= `imem_rdata` (byte-swapped if SWAP_BYTES), `ir_valid` <= 1, go to IDLE.
  - Else, if TIMEOUT≠0 and `wait_cnt`==TIMEOUT-1: `ir` <= ERR_WORD, `ir_valid` <= 1, `fetch_err` <= 1, go to ERR.
  - Else: `wait_cnt` <= `wait_cnt`+1.
- ERR: `imem_req`=0, `stall`=1. The only exit is reset.
- `stall` = (state==REQ) | (state==ERR), combinational.
- `phase_f` while in REQ or ERR is ignored: no new capture, no change to `addr_r`.
- `imem_ack` outside REQ is ignored.
- `hlt`=1:
  - next state IDLE; `imem_req` drops at that edge; no `ir_valid`.
  - `ir` and `fetch_err` keep their values; state ERR is left only by `n_rst`.
  - `hlt` beats a simultaneous `imem_ack` and a simultaneous timeout.
- An ack in the same cycle as the timeout is taken as success: no error.
- `wait_cnt` is `$clog2(TIMEOUT+1)` bits wide and never wraps, because it is cleared on entry to REQ.

## Timing
- Reset (`n_rst`=0 at an edge): state IDLE, `imem_req`=0, `imem_addr`=0, `ir`=0, `ir_valid`=0, `stall`=0, `fetch_err`=0, `addr_r`=0, `wait_cnt`=0. This includes reset in the middle of a fetch.
- Capture at edge E0 (`phase_f`=1 in IDLE): `imem_req`=1 from E0 to the ack edge.
- Ack sampled at edge Ek (k≥1): `ir` and `ir_valid`=1 visible after Ek. `stall` and `imem_req` are 0 after Ek.
- Zero-wait memory (ack in the first REQ cycle): `phase_f` to `ir_valid` = 2 edges.
- Back-to-back throughput: one fetch per 2 cycles. A new `phase_f` is accepted in the same cycle that `ir_valid`=1.
- Timeout: the error edge is the TIMEOUT-th edge after entering REQ.

## Structure
- Shared package entries:
  - state encoding IDLE=2'd0, REQ=2'd1, ERR=2'd2;
  - `WORD_MASK` 32'hFFFF_FFFC, the same alignment mask the program counter uses.
- Single module. An optional sub-module `byte_swap32` (pure combinational) is reused by the data-memory side.

## Test plan
- Zero-wait: `pc`=32'h0000_0104, `phase_f` 1 cycle, `imem_ack` with `imem_rdata`=32'hDEAD_BEEF in the first REQ cycle -> `imem_addr`=32'h104 for 1 cycle, `ir`=32'hDEAD_BEEF, `ir_valid` pulses exactly once, `stall` high for 1 cycle.
- Wait states and stray strobes: ack after 5 cycles; `phase_f` pulsed during the wait with `pc`=32'h200 -> `imem_addr` stays 32'h104 throughout, `stall` high for 5 cycles, only one fetch.
- Unaligned input: `pc`=32'h0000_0107 -> `imem_addr`=32'h104.
- Timeout: TIMEOUT=4, no ack -> after 4 REQ cycles `ir`=ERR_WORD, `fetch_err`=1, `stall` stays 1. Asserting `hlt` does not clear the error; only `n_rst` does.
- Abort: `hlt` asserted in the same cycle as `imem_ack` -> `ir` unchanged, no `ir_valid`, `imem_req`=0 after the edge.
- Reset mid-fetch: `n_rst`=0 in the 2nd REQ cycle -> every output at its reset value after the edge; a late `imem_ack` is ignored. With SWAP_BYTES=1, data 32'h1122_3344 -> `ir`=32'h4433_2211.
